// File: rtl/player_ctl_if.sv
// State encoding shared by the controller and draw_player, plus the draw_player bus.
// master = player_ctl (producer), slave = draw_player (consumer).
package state_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RIGHT = 2'd1,
    LEFT  = 2'd2
  } State;
endpackage

interface player_ctl_if;
  logic [11:0]     player_xpos;
  logic [11:0]     player_ypos;
  state_pkg::State state;

  modport master (output player_xpos, output player_ypos, output state);
  modport slave  (input  player_xpos, input  player_ypos, input  state);
endinterface

// File: rtl/player_ctl.sv
// Player position/state controller: key levels -> xpos/ypos/State, updated once per frame.
// Optional jump physics enabled by defining PLAYER_JUMP_EN.
module player_ctl
  import state_pkg::*;
#(
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 984,
  parameter int X_INIT   = 0,
  parameter int Y_GROUND = 420,
  parameter int STEP     = 4,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vsync,
  input  logic            key_left,
  input  logic            key_right,
  input  logic            key_jump,
  player_ctl_if.master    pif
);

  localparam int KEY_L = 0;
  localparam int KEY_R = 1;
  localparam int KEY_J = 2;
  localparam int NKEYS = 3;

  localparam logic [12:0] X_MIN13 = 13'(X_MIN);
  localparam logic [12:0] X_MAX13 = 13'(X_MAX);
  localparam logic [12:0] STEP13  = 13'(STEP);
  localparam logic [12:0] LO_LIM  = 13'(X_MIN + STEP);
  localparam logic [12:0] HI_LIM  = 13'(X_MAX - STEP);

  logic key_raw      [NKEYS];
  logic key_meta_reg [NKEYS];
  logic key_sync_reg [NKEYS];

  assign key_raw[KEY_L] = key_left;
  assign key_raw[KEY_R] = key_right;
  assign key_raw[KEY_J] = key_jump;

  // Two-flop synchronisers; keys come from an unrelated keyboard clock
  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (rst) begin
          key_meta_reg[gi] <= 1'b0;
          key_sync_reg[gi] <= 1'b0;
        end else begin
          key_meta_reg[gi] <= key_raw[gi];
          key_sync_reg[gi] <= key_meta_reg[gi];
        end
      end
    end
  endgenerate

  logic vsync_q_reg, vsync_q2_reg;
  logic tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q_reg  <= 1'b0;
      vsync_q2_reg <= 1'b0;
    end else begin
      vsync_q_reg  <= vsync;
      vsync_q2_reg <= vsync_q_reg;
    end
  end

  assign tick = vsync_q_reg & ~vsync_q2_reg;

  // Horizontal FSM: state register
  State        state_reg, state_next;
  logic [11:0] xpos_reg, xpos_next;
  logic [12:0] xpos_ext;

  assign xpos_ext = {1'b0, xpos_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      xpos_reg  <= 12'(X_INIT);
    end else begin
      state_reg <= state_next;
      xpos_reg  <= xpos_next;
    end
  end

  // Next-state: decided fresh every tick, no memory of the previous direction
  always_comb begin
    state_next = state_reg;
    if (tick) begin
      if (key_sync_reg[KEY_L] && !key_sync_reg[KEY_R])
        state_next = LEFT;
      else if (key_sync_reg[KEY_R] && !key_sync_reg[KEY_L])
        state_next = RIGHT;
      else
        state_next = IDLE;
    end
  end

  // Position follows the new direction in the same cycle, saturating at the bounds
  always_comb begin
    xpos_next = xpos_reg;
    if (tick) begin
      case (state_next)
        LEFT:    xpos_next = (xpos_ext < LO_LIM) ? 12'(X_MIN13) : 12'(xpos_ext - STEP13);
        RIGHT:   xpos_next = (xpos_ext > HI_LIM) ? 12'(X_MAX13) : 12'(xpos_ext + STEP13);
        default: xpos_next = xpos_reg;
      endcase
    end
  end

  assign pif.player_xpos = xpos_reg;
  assign pif.state       = state_reg;

`ifdef PLAYER_JUMP_EN
  typedef enum logic {GROUNDED = 1'b0, AIRBORNE = 1'b1} vstate_t;

  localparam logic signed [12:0] Y_GND_S  = 13'(Y_GROUND);
  localparam logic signed [7:0]  JUMP_V8  = 8'(JUMP_V);
  localparam logic signed [7:0]  GRAV8    = 8'(GRAVITY);

  vstate_t            vstate_reg, vstate_next;
  logic signed [7:0]  vy_reg, vy_next;
  logic [11:0]        ypos_reg, ypos_next;
  logic               jump_prev_reg;
  logic               jump_rise;
  logic signed [12:0] y_step;
  logic               y_landed;

  // Edge detection is sampled only at ticks, so a held key never re-launches
  assign jump_rise = key_sync_reg[KEY_J] & ~jump_prev_reg;
  assign y_step    = $signed({1'b0, ypos_reg}) - $signed({{5{vy_reg[7]}}, vy_reg});
  assign y_landed  = (y_step >= Y_GND_S);

  always_ff @(posedge clk) begin
    if (rst) begin
      vstate_reg    <= GROUNDED;
      vy_reg        <= 8'sd0;
      ypos_reg      <= 12'(Y_GROUND);
      jump_prev_reg <= 1'b0;
    end else begin
      vstate_reg <= vstate_next;
      vy_reg     <= vy_next;
      ypos_reg   <= ypos_next;
      if (tick)
        jump_prev_reg <= key_sync_reg[KEY_J];
    end
  end

  always_comb begin
    vstate_next = vstate_reg;
    if (tick) begin
      case (vstate_reg)
        GROUNDED: if (jump_rise) vstate_next = AIRBORNE;
        AIRBORNE: if (y_landed)  vstate_next = GROUNDED;
        default:  vstate_next = GROUNDED;
      endcase
    end
  end

  // The launch tick only loads the speed; motion starts on the following tick
  always_comb begin
    vy_next   = vy_reg;
    ypos_next = ypos_reg;
    if (tick) begin
      case (vstate_reg)
        GROUNDED: if (jump_rise) vy_next = JUMP_V8;
        AIRBORNE: begin
          if (y_landed) begin
            ypos_next = 12'(Y_GROUND);
            vy_next   = 8'sd0;
          end else begin
            ypos_next = y_step[11:0];
            vy_next   = vy_reg - GRAV8;
          end
        end
        default: begin
          ypos_next = 12'(Y_GROUND);
          vy_next   = 8'sd0;
        end
      endcase
    end
  end

  assign pif.player_ypos = ypos_reg;
`else
  logic unused_jump;
  assign unused_jump     = key_sync_reg[KEY_J] ^ (JUMP_V != 0) ^ (GRAVITY != 0);
  assign pif.player_ypos = 12'(Y_GROUND);
`endif

endmodule

// File: tb/tb_player_ctl.sv
// Directed bench for player_ctl: a per-frame vector table plus bound, reset and jump sequences.
// Jump sequences are compiled only when PLAYER_JUMP_EN is defined.
`timescale 1ns/1ps
module tb_player_ctl;
  import state_pkg::*;

  logic clk = 1'b0;
  logic rst, vsync, key_left, key_right, key_jump;

  always #5 clk = ~clk;

  player_ctl_if pif ();
  player_ctl_if pif2 ();

  player_ctl dut (
    .clk(clk), .rst(rst), .vsync(vsync),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
    .pif(pif)
  );

  // Second instance starts off-grid so the left bound is hit with a partial step
  player_ctl #(.X_INIT(2)) dut2 (
    .clk(clk), .rst(rst), .vsync(vsync),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
    .pif(pif2)
  );

  typedef struct {
    logic        l;
    logic        r;
    logic [11:0] exp_x;
    State        exp_st;
  } vec_t;

  vec_t vecs [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic set_keys(input logic l, input logic r, input logic j);
    key_left  = l;
    key_right = r;
    key_jump  = j;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // One frame of 8 clocks containing exactly one vsync rising edge
  task automatic frame();
    @(posedge clk); #1 vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1 vsync = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic add_vec(input logic l, input logic r, input int x, input State st);
    vec_t v;
    v.l = l; v.r = r; v.exp_x = 12'(x); v.exp_st = st;
    vecs.push_back(v);
  endtask

`ifdef PLAYER_JUMP_EN
  int y_m, vy_m;
`endif

  initial begin
    rst = 1'b1; vsync = 1'b0; key_left = 1'b0; key_right = 1'b0; key_jump = 1'b0;

    for (int i = 0; i < 5; i++)  add_vec(1'b0, 1'b0, 0, IDLE);
    for (int i = 1; i <= 10; i++) add_vec(1'b0, 1'b1, 4 * i, RIGHT);
    for (int i = 0; i < 3; i++)  add_vec(1'b1, 1'b1, 40, IDLE);
    add_vec(1'b1, 1'b0, 36, LEFT);
    add_vec(1'b0, 1'b0, 36, IDLE);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_xpos", pif.player_xpos, 12'd0);
    chk("reset_ypos", pif.player_ypos, 12'd420);
    chk("reset_state", 12'(pif.state), 12'(IDLE));
    rst = 1'b0;

    foreach (vecs[i]) begin
      set_keys(vecs[i].l, vecs[i].r, 1'b0);
      frame();
      $display("vec %0d: l=%0b r=%0b -> xpos=%0d ypos=%0d state=%0d",
               i, vecs[i].l, vecs[i].r, pif.player_xpos, pif.player_ypos, pif.state);
      chk($sformatf("vec%0d_xpos", i), pif.player_xpos, vecs[i].exp_x);
      chk($sformatf("vec%0d_state", i), 12'(pif.state), 12'(vecs[i].exp_st));
      chk($sformatf("vec%0d_ypos", i), pif.player_ypos, 12'd420);
    end

    // Short right pulse entirely between two ticks must not move the player
    key_right = 1'b1;
    repeat (4) @(posedge clk);
    #1 key_right = 1'b0;
    chk("pulse_hold_mid", pif.player_xpos, 12'd36);
    repeat (4) @(posedge clk);
    frame();
    $display("pulse: xpos=%0d state=%0d", pif.player_xpos, pif.state);
    chk("pulse_xpos", pif.player_xpos, 12'd36);
    chk("pulse_state", 12'(pif.state), 12'(IDLE));

    // Walk up to the right bound
    set_keys(1'b0, 1'b1, 1'b0);
    repeat (236) frame();
    $display("walk right: xpos=%0d state=%0d", pif.player_xpos, pif.state);
    chk("walk_980", pif.player_xpos, 12'd980);
    frame();
    $display("right bound: xpos=%0d state=%0d", pif.player_xpos, pif.state);
    chk("bound_984", pif.player_xpos, 12'd984);
    repeat (2) frame();
    $display("right bound held: xpos=%0d state=%0d", pif.player_xpos, pif.state);
    chk("bound_984_hold", pif.player_xpos, 12'd984);
    chk("bound_state_right", 12'(pif.state), 12'(RIGHT));

    // Reset while moving takes effect on the next clock
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    $display("reset mid-motion: xpos=%0d state=%0d", pif.player_xpos, pif.state);
    chk("rst_mid_xpos", pif.player_xpos, 12'd0);
    chk("rst_mid_state", 12'(pif.state), 12'(IDLE));
    chk("rst_mid_x2", pif2.player_xpos, 12'd2);
    rst = 1'b0;

    // Left bound from xpos=2: clamps to 0, never wraps
    set_keys(1'b1, 1'b0, 1'b0);
    frame();
    $display("left bound: x=%0d x2=%0d st2=%0d", pif.player_xpos, pif2.player_xpos, pif2.state);
    chk("lbound_x2", pif2.player_xpos, 12'd0);
    chk("lbound_st2", 12'(pif2.state), 12'(LEFT));
    chk("lbound_x", pif.player_xpos, 12'd0);
    frame();
    chk("lbound_x2_hold", pif2.player_xpos, 12'd0);
    chk("lbound_st_hold", 12'(pif.state), 12'(LEFT));
    set_keys(1'b0, 1'b0, 1'b0);

`ifdef PLAYER_JUMP_EN
    do_reset();
    set_keys(1'b0, 1'b1, 1'b1);
    frame();
    chk("jump_launch_y", pif.player_ypos, 12'd420);
    y_m = 420; vy_m = 12;
    for (int f = 0; f < 40 && vy_m != 0 || f == 0; f++) begin
      y_m = y_m - vy_m; vy_m = vy_m - 1;
      if (y_m >= 420) begin y_m = 420; vy_m = 0; end
      frame();
      $display("jump frame %0d: ypos=%0d xpos=%0d", f, pif.player_ypos, pif.player_xpos);
      chk($sformatf("jump_y%0d", f), pif.player_ypos, 12'(y_m));
    end
    repeat (3) frame();
    chk("jump_held_no_retrigger", pif.player_ypos, 12'd420);
    set_keys(1'b0, 1'b1, 1'b0);
    frame();
    set_keys(1'b0, 1'b1, 1'b1);
    frame();
    frame();
    chk("jump2_first", pif.player_ypos, 12'd408);
    frame();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    $display("reset mid-jump: xpos=%0d ypos=%0d state=%0d", pif.player_xpos, pif.player_ypos, pif.state);
    chk("rst_jump_x", pif.player_xpos, 12'd0);
    chk("rst_jump_y", pif.player_ypos, 12'd420);
    chk("rst_jump_state", 12'(pif.state), 12'(IDLE));
    rst = 1'b0;
    set_keys(1'b0, 1'b0, 1'b0);
`else
    set_keys(1'b0, 1'b0, 1'b1);
    frame();
    $display("jump disabled: ypos=%0d", pif.player_ypos);
    chk("nojump_ypos", pif.player_ypos, 12'd420);
    set_keys(1'b0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
